// File: rtl/mmu_pkg.sv
// Shared types and sizing for the systolic array result drain sequencer.
// Everything that sizes a port or register lives here so the files agree.
package mmu_pkg;

  localparam int WIDTH     = 8;
  localparam int LENGTH    = 5;
  localparam int MAX_BEATS = 255;

  localparam int BW   = $clog2(MAX_BEATS + 1);
  localparam int CNTW = $clog2(MAX_BEATS + 2 * (LENGTH - 1) + 1);
  localparam int IDXW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int ROWW = LENGTH * 2 * WIDTH;

  typedef logic [2*WIDTH-1:0] psum_t;
  typedef psum_t [0:LENGTH-1] psum_row_t;
  typedef psum_row_t [0:LENGTH-1] psum_mat_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    CAPTURE,
    DRAIN
  } drain_state_e;

  // Enable window covers the skew: the far-corner PE finishes 2*(LENGTH-1) beats late.
  function automatic logic [CNTW-1:0] computeCycles(input logic [BW-1:0] beats);
    return CNTW'(beats) + CNTW'(2 * (LENGTH - 1));
  endfunction

endpackage

// File: rtl/mmu_result_drain_if.sv
// Job command, array control and row-stream signals between the drain
// sequencer (slave side) and its surroundings (master side).
interface mmu_result_drain_if;
  import mmu_pkg::*;

  logic             Start;
  logic [BW-1:0]    Beats;
  psum_mat_t        PsumOut;
  logic             MmuEn;
  logic             MmuClr;
  logic             Busy;
  logic             RowValid;
  logic             RowReady;
  logic [ROWW-1:0]  RowData;
  logic [IDXW-1:0]  RowIdx;
  logic             RowLast;

  modport master (
    output Start, Beats, PsumOut, RowReady,
    input  MmuEn, MmuClr, Busy, RowValid, RowData, RowIdx, RowLast
  );

  modport slave (
    input  Start, Beats, PsumOut, RowReady,
    output MmuEn, MmuClr, Busy, RowValid, RowData, RowIdx, RowLast
  );

endinterface

// File: rtl/mmu_result_snapshot.sv
// LENGTH x LENGTH capture bank holding the array results while they drain,
// so the array can be cleared and reused immediately after capture.
module mmu_result_snapshot
  import mmu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_sync_rst,
  input  logic            i_load,
  input  psum_mat_t       i_psum,
  input  logic [IDXW-1:0] i_sel,
  output psum_row_t       o_row
);

  psum_mat_t r_bank;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_bank <= '0;
    end else if (i_load) begin
      r_bank <= i_psum;
    end
  end

  // Out-of-range selects read as zero rather than aliasing a real row.
  always_comb begin
    o_row = '0;
    for (int r = 0; r < LENGTH; r++) begin
      if (i_sel == IDXW'(r)) begin
        o_row = r_bank[r];
      end
    end
  end

endmodule

// File: rtl/mmu_result_drain.sv
// Output-side sequencer for the systolic multiply array: times the enable
// window, snapshots and clears the array, then streams rows via valid/ready.
module mmu_result_drain
  import mmu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_sync_rst,
  mmu_result_drain_if.slave bus
);

  drain_state_e    r_state;
  logic [CNTW-1:0] r_cnt;
  logic            r_mmuEn;
  logic            r_mmuClr;
  logic            r_busy;
  logic            r_rowValid;
  logic [IDXW-1:0] r_rowIdx;
  logic            r_rowLast;

  logic            w_snapLoad;
  psum_row_t       w_snapRow;
  logic [ROWW-1:0] w_rowData;

  // Capture happens on the same edge the array clears, so the bank sees pre-clear sums.
  assign w_snapLoad = (r_state == CAPTURE);

  mmu_result_snapshot u_snapshot (
    .i_clk      (i_clk),
    .i_sync_rst (i_sync_rst),
    .i_load     (w_snapLoad),
    .i_psum     (bus.PsumOut),
    .i_sel      (r_rowIdx),
    .o_row      (w_snapRow)
  );

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mmuEn    <= 1'b0;
      r_mmuClr   <= 1'b0;
      r_busy     <= 1'b0;
      r_rowValid <= 1'b0;
      r_rowIdx   <= '0;
      r_rowLast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start && (bus.Beats != '0)) begin
            r_state <= COMPUTE;
            r_cnt   <= computeCycles(bus.Beats);
            r_mmuEn <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            r_state  <= CAPTURE;
            r_mmuEn  <= 1'b0;
            r_mmuClr <= 1'b1;
          end
        end
        CAPTURE: begin
          r_state    <= DRAIN;
          r_mmuClr   <= 1'b0;
          r_rowValid <= 1'b1;
          r_rowIdx   <= '0;
          r_rowLast  <= (LENGTH == 1);
        end
        DRAIN: begin
          if (bus.RowReady) begin
            if (r_rowLast) begin
              r_state    <= IDLE;
              r_rowValid <= 1'b0;
              r_rowLast  <= 1'b0;
              r_rowIdx   <= '0;
              r_busy     <= 1'b0;
            end else begin
              r_rowIdx  <= r_rowIdx + IDXW'(1);
              r_rowLast <= (r_rowIdx == IDXW'(LENGTH - 2));
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Element c sits at the low end of the bus for c = 0; data is forced to zero outside DRAIN.
  always_comb begin
    w_rowData = '0;
    if (r_rowValid) begin
      for (int c = 0; c < LENGTH; c++) begin
        w_rowData[c*2*WIDTH +: 2*WIDTH] = w_snapRow[c];
      end
    end
  end

  assign bus.MmuEn    = r_mmuEn;
  assign bus.MmuClr   = r_mmuClr;
  assign bus.Busy     = r_busy;
  assign bus.RowValid = r_rowValid;
  assign bus.RowData  = w_rowData;
  assign bus.RowIdx   = r_rowIdx;
  assign bus.RowLast  = r_rowLast;

endmodule

// File: tb/tb_mmu_result_drain.sv
// Directed bench for mmu_result_drain: enable window length, capture timing,
// row streaming with back-pressure, ignored starts and mid-job reset.
module tb_mmu_result_drain;
  import mmu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mmu_result_drain_if bus ();

  mmu_result_drain dut (
    .i_clk      (clk),
    .i_sync_rst (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected row r: element c = 16*r + c, element 0 in the low bits.
  function automatic logic [ROWW-1:0] expRow(input int r);
    logic [ROWW-1:0] v;
    v = '0;
    for (int c = 0; c < LENGTH; c++) begin
      v[c*2*WIDTH +: 2*WIDTH] = psum_t'(16 * r + c);
    end
    return v;
  endfunction

  task automatic loadStub();
    for (int r = 0; r < LENGTH; r++)
      for (int c = 0; c < LENGTH; c++)
        bus.PsumOut[r][c] = psum_t'(16 * r + c);
  endtask

  task automatic scrambleStub();
    for (int r = 0; r < LENGTH; r++)
      for (int c = 0; c < LENGTH; c++)
        bus.PsumOut[r][c] = psum_t'(16'hBE00 + 3 * r + 7 * c + 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " MmuEn"},    128'(bus.MmuEn),    128'd0);
    checkOutput({tag, " MmuClr"},   128'(bus.MmuClr),   128'd0);
    checkOutput({tag, " Busy"},     128'(bus.Busy),     128'd0);
    checkOutput({tag, " RowValid"}, 128'(bus.RowValid), 128'd0);
    checkOutput({tag, " RowData"},  128'(bus.RowData),  128'd0);
    checkOutput({tag, " RowIdx"},   128'(bus.RowIdx),   128'd0);
    checkOutput({tag, " RowLast"},  128'(bus.RowLast),  128'd0);
  endtask

  // Issues Start at a falling edge, counts the enable window, checks clear and first valid.
  task automatic applyStimulus(input int beats, input int expectedEn, input bit pulseDuring, input string tag);
    int enCount;
    bit busyOk;
    loadStub();
    bus.Start = 1'b1;
    bus.Beats = BW'(beats);
    @(negedge clk);
    bus.Start = 1'b0;
    enCount = 0;
    busyOk = 1'b1;
    while (bus.MmuEn === 1'b1 && enCount < 400) begin
      enCount++;
      if (bus.Busy !== 1'b1) busyOk = 1'b0;
      if (bus.MmuClr !== 1'b0) busyOk = 1'b0;
      bus.Start = pulseDuring && (enCount == 3);
      bus.Beats = pulseDuring ? BW'(7) : BW'(beats);
      @(negedge clk);
    end
    bus.Start = 1'b0;
    checkOutput({tag, " MmuEn cycles"},     128'(enCount),      128'(expectedEn));
    checkOutput({tag, " Busy in compute"},  128'(busyOk),       128'd1);
    checkOutput({tag, " MmuClr capture"},   128'(bus.MmuClr),   128'd1);
    checkOutput({tag, " Busy capture"},     128'(bus.Busy),     128'd1);
    checkOutput({tag, " RowValid capture"}, 128'(bus.RowValid), 128'd0);
    @(negedge clk);
    scrambleStub();
    checkOutput({tag, " MmuClr after"},     128'(bus.MmuClr),   128'd0);
    checkOutput({tag, " first RowValid"},   128'(bus.RowValid), 128'd1);
  endtask

  // Streams all rows, optionally stalling one row and pulsing Start mid-drain.
  task automatic drainRows(input int stallRow, input int stallCycles, input bit pulseDuring, input string tag);
    for (int r = 0; r < LENGTH; r++) begin
      checkOutput($sformatf("%s row%0d RowValid", tag, r), 128'(bus.RowValid), 128'd1);
      checkOutput($sformatf("%s row%0d RowIdx", tag, r),   128'(bus.RowIdx),   128'(r));
      checkOutput($sformatf("%s row%0d RowLast", tag, r),  128'(bus.RowLast),  128'(r == LENGTH - 1));
      checkOutput($sformatf("%s row%0d RowData", tag, r),  128'(bus.RowData),  128'(expRow(r)));
      checkOutput($sformatf("%s row%0d Busy", tag, r),     128'(bus.Busy),     128'd1);
      if (r == stallRow) begin
        bus.RowReady = 1'b0;
        for (int s = 0; s < stallCycles; s++) begin
          @(negedge clk);
          checkOutput($sformatf("%s stall%0d RowValid", tag, s), 128'(bus.RowValid), 128'd1);
          checkOutput($sformatf("%s stall%0d RowIdx", tag, s),   128'(bus.RowIdx),   128'(r));
          checkOutput($sformatf("%s stall%0d RowData", tag, s),  128'(bus.RowData),  128'(expRow(r)));
        end
        bus.RowReady = 1'b1;
      end
      bus.Start = pulseDuring && (r == 1);
      bus.Beats = BW'(7);
      @(negedge clk);
      bus.Start = 1'b0;
    end
    checkOutput({tag, " end RowValid"}, 128'(bus.RowValid), 128'd0);
    checkOutput({tag, " end RowLast"},  128'(bus.RowLast),  128'd0);
    checkOutput({tag, " end Busy"},     128'(bus.Busy),     128'd0);
    @(negedge clk);
    checkOutput({tag, " idle MmuEn"},   128'(bus.MmuEn),    128'd0);
    checkOutput({tag, " idle Busy"},    128'(bus.Busy),     128'd0);
  endtask

  initial begin
    bus.Start    = 1'b0;
    bus.Beats    = '0;
    bus.RowReady = 1'b1;
    bus.PsumOut  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkAllZero("reset");

    applyStimulus(3, 11, 1'b0, "s1");
    drainRows(-1, 0, 1'b0, "s2");

    applyStimulus(3, 11, 1'b0, "s3");
    drainRows(2, 3, 1'b0, "s3");

    applyStimulus(3, 11, 1'b1, "s4");
    drainRows(-1, 0, 1'b1, "s4");

    bus.Start = 1'b1;
    bus.Beats = '0;
    @(negedge clk);
    bus.Start = 1'b0;
    checkOutput("s5 Busy",     128'(bus.Busy),     128'd0);
    checkOutput("s5 MmuEn",    128'(bus.MmuEn),    128'd0);
    @(negedge clk);
    checkOutput("s5 RowValid", 128'(bus.RowValid), 128'd0);
    checkOutput("s5 Busy late", 128'(bus.Busy),    128'd0);

    applyStimulus(3, 11, 1'b0, "s6");
    checkOutput("s6 row0 RowIdx", 128'(bus.RowIdx), 128'd0);
    @(negedge clk);
    checkOutput("s6 row1 RowIdx", 128'(bus.RowIdx), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("s6 abort");
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("s6 idle");
    applyStimulus(1, 9, 1'b0, "s6 fresh");
    drainRows(-1, 0, 1'b0, "s6 fresh");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
